// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - MSB-first parallel-to-serial transmitter with sof/valid framing.
// Optional even-parity trailer bit when PARITY_EN is defined.
module serial_tx #(
  parameter int DW = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [SW-1:0] sel,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic          sof,
  output logic          sout,
  output logic          sout_vld,
  output logic          done
);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          ready_q, ready_d;
  logic          sof_q, sof_d;
  logic          sout_q, sout_d;
  logic          sout_vld_q, sout_vld_d;
  logic          done_q, done_d;
`ifdef PARITY_EN
  logic          par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = data;
          cnt_d   = sel;
          state_d = SEND;
`ifdef PARITY_EN
          par_d   = data[sel];
`endif
        end
      end
      SEND: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SW'(1);
`ifdef PARITY_EN
          par_d = par_q ^ shreg_q[cnt_d];
`endif
        end else begin
`ifdef PARITY_EN
          state_d = PAR;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PARITY_EN
      PAR: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are the registered image of the next state, so they lag nothing and
    // never see load/sel/data combinationally.
    sout_d = 1'b0;
    case (state_d)
      SEND: sout_d = shreg_d[cnt_d];
`ifdef PARITY_EN
      PAR:  sout_d = par_d;
`endif
      default: sout_d = 1'b0;
    endcase
    sout_vld_d = (state_d != IDLE);
    ready_d    = (state_d == IDLE);
    sof_d      = (state_q == IDLE) && (state_d == SEND);
    done_d     = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      ready_q    <= 1'b1;
      sof_q      <= 1'b0;
      sout_q     <= 1'b0;
      sout_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      ready_q    <= ready_d;
      sof_q      <= sof_d;
      sout_q     <= sout_d;
      sout_vld_q <= sout_vld_d;
      done_q     <= done_d;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
  end
`endif

  assign ready    = ready_q;
  assign sof      = sof_q;
  assign sout     = sout_q;
  assign sout_vld = sout_vld_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx (plain or PARITY_EN build).
module tb_serial_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [2:0] sel;
  logic [7:0] data;
  logic       ready, sof, sout, sout_vld, done;

  typedef struct {
    logic b;
    logic s;
    logic l;
  } exp_t;

  exp_t q[$];
  logic pend = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  serial_tx #(.DW(8), .SW(3)) dut (
    .clk(clk), .rst(rst), .load(load), .sel(sel), .data(data),
    .ready(ready), .sof(sof), .sout(sout), .sout_vld(sout_vld), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [2:0] s, input logic [7:0] d);
    exp_t e;
    logic p;
    p = 1'b0;
    for (int i = int'(s); i >= 0; i--) begin
      e.b = d[i];
      e.s = (i == int'(s));
`ifdef PARITY_EN
      e.l = 1'b0;
`else
      e.l = (i == 0);
`endif
      p = p ^ d[i];
      q.push_back(e);
    end
`ifdef PARITY_EN
    e.b = p;
    e.s = 1'b0;
    e.l = 1'b1;
    q.push_back(e);
`endif
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!ready && k < 100) begin
      tick();
      k++;
    end
    if (!ready) check_eq("ready_timeout", ready, 1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((q.size() != 0 || pend) && k < 200) begin
      tick();
      k++;
    end
    check_eq("drain", q.size(), 0);
    tick();
  endtask

  task automatic send(input logic [2:0] s, input logic [7:0] d);
    wait_ready();
    sel  = s;
    data = d;
    load = 1'b1;
    push_frame(s, d);
    tick();
    load = 1'b0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q.delete();
      pend = 1'b0;
    end else begin
      check_eq("done", done, pend);
      if (pend) begin
        check_eq("done_ready", ready, 1);
        check_eq("done_gap_vld", sout_vld, 0);
      end
      if (sout_vld) begin
        if (q.size() == 0) begin
          check_eq("unexpected_bit", sout_vld, 0);
          pend = 1'b0;
        end else begin
          e = q.pop_front();
          check_eq("sout", sout, e.b);
          check_eq("sof", sof, e.s);
          check_eq("busy_ready", ready, 0);
          pend = e.l;
        end
      end else begin
        check_eq("idle_sof", sof, 0);
        check_eq("idle_sout", sout, 0);
        pend = 1'b0;
      end
    end
  end

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    sel  = '0;
    data = '0;
    tick();
    tick();
    check_eq("rst_ready", ready, 1);
    check_eq("rst_sof", sof, 0);
    check_eq("rst_sout", sout, 0);
    check_eq("rst_vld", sout_vld, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_ready", ready, 1);
      check_eq("idle_vld", sout_vld, 0);
    end

    send(3'd7, 8'hA5);
    wait_drain();

    send(3'd0, 8'hFE);
    check_eq("one_bit_vld", sout_vld, 1);
    check_eq("one_bit_sof", sof, 1);
    wait_drain();

    // A load while busy must be dropped.
    send(3'd4, 8'h13);
    tick();
    tick();
    load = 1'b1;
    sel  = 3'd7;
    data = 8'hFF;
    check_eq("ignored_ready", ready, 0);
    tick();
    load = 1'b0;
    wait_drain();
    for (int i = 0; i < 3; i++) tick();

    // Back-to-back with load held high.
    wait_ready();
    sel  = 3'd2;
    data = 8'h05;
    load = 1'b1;
    push_frame(3'd2, 8'h05);
    tick();
    data = 8'h02;
    push_frame(3'd2, 8'h02);
    for (int k = 0; k < 20 && !ready; k++) tick();
    check_eq("b2b_done", done, 1);
    tick();
    load = 1'b0;
    check_eq("b2b_gap_vld", sout_vld, 1);
    check_eq("b2b_gap_sof", sof, 1);
    wait_drain();

    // Asynchronous reset mid-frame.
    send(3'd7, 8'h3C);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_ready", ready, 1);
    check_eq("arst_sof", sof, 0);
    check_eq("arst_sout", sout, 0);
    check_eq("arst_vld", sout_vld, 0);
    check_eq("arst_done", done, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    send(3'd1, 8'h02);
    wait_drain();

    for (int i = 0; i < 3; i++) tick();
    check_eq("final_queue", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial transmitter for the lab's serial link; the sending end paired with the down-counter-driven serial receiver. Accepts a word of 1 to DW bits, selected by a 3-bit length code, when idle. Shifts the word out MSB-first, one bit per clock, and marks the frame with a start pulse and a valid strobe. The frame timing matches what the receiver's load/shift/write sequencing expects.

## Interface
- DW, 8: data word width; maximum frame length.
- SW, 3: length-code width; must equal $clog2(DW).
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- load  input  1  start request; accepted only on a rising edge where ready=1.
- sel  input  SW  length code; frame carries sel+1 data bits.
- data  input  DW  word to send; bits data[sel] down to data[0] are transmitted.
- ready  output  1  idle, able to accept load.
- sof  output  1  one-cycle pulse coincident with the first data bit (drives receiver load).
- sout  output  1  serial data bit.
- sout_vld  output  1  high on every cycle sout carries a frame bit (receiver shift).
- done  output  1  one-cycle pulse in the first idle cycle after the last bit.

## Operation
- States: IDLE, SEND (plus PAR when PARITY_EN is defined).
- IDLE: ready=1, sout_vld=0, sout=0.
  - On load=1, capture data into the shift register.
  - Capture sel into the bit counter `cnt` and go to SEND.
- SEND: sout = shift-register bit at index cnt, sout_vld=1, ready=0.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: next state is IDLE, or PAR if enabled.
- sof=1 only in the first SEND cycle of a frame.
- Bits above index sel are never driven on sout.
- load while ready=0 is ignored: no queuing, no effect on the current frame.
- data and sel are sampled only at acceptance. Later changes have no effect on the frame in flight.
- sel=0 gives a 1-bit frame: sof and sout_vld both high for one cycle.
- sel=DW-1 gives a full-width frame of DW bits.
- done=1 for exactly the one cycle after the final frame bit (data or parity). ready is also 1 in that cycle.
- A load in the done cycle is accepted. Back-to-back frames are separated by exactly one cycle with sout_vld=0.
- Counter arithmetic is SW-bit unsigned. cnt never wraps, because decrement is inhibited at 0.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, ready=1, sof=0, sout=0, sout_vld=0, done=0, cnt=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is generated.
- Latency: load accepted at edge N. The first bit, with sof, is on sout at edge N+1.
- The last data bit is on sout after edge N+1+sel.
- done and ready=1 occur after edge N+2+sel, or N+3+sel with parity.
- All outputs are registered; none depends combinationally on load, sel or data.

## Configuration
- PARITY_EN defined:
  - After the last data bit, one extra PAR cycle drives sout = even parity (XOR) of the transmitted bits data[sel:0].
  - sout_vld=1 during PAR; sof=0.
  - The frame lasts sel+2 cycles.
- PARITY_EN undefined:
  - No PAR state.
  - The frame lasts exactly sel+1 cycles, bit-compatible with the plain receiver.

## Test plan
- Reset, then idle 5 cycles -> ready=1, sout_vld=0, sof=0, done=0 throughout.
- load=1, sel=3'd7, data=8'hA5 -> sout sequence 1,0,1,0,0,1,0,1 over 8 cycles.
  - sof on the first cycle only; done one cycle after the last bit.
  - With PARITY_EN: 9th bit is 0.
- load=1, sel=3'd0, data=8'hFE -> a single bit 0 with sof=sout_vld=1 for one cycle.
  - Next cycle: done=1, ready=1.
- Mid-frame disturbance: sel=3'd4, data=8'h13; pulse load again with data=8'hFF at bit 2 -> second load ignored, sout = 1,0,0,1,1.
- Back-to-back: load held high with sel=3'd2, data=8'h05, then data=8'h02 -> bits 1,0,1, one gap cycle (done=1, sout_vld=0), then bits 0,1,0.
- Reset at bit 3 of an 8-bit frame -> all outputs return to reset values asynchronously, no done pulse.
  - After release, a new sel=3'd1, data=8'h02 frame sends 1,0.
